// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   Forwarding and load-use hazard unit placed beside the ID/EX boundary.
//   It keeps its own shadow pipeline of destination tags from EX (stage 0)
//   down to the last forwarding stage (stage DEPTH). From that pipeline it
//   produces per-operand forward selects for the EX instruction. It also
//   detects load-use hazards at ID, requests a stall and inserts a bubble.
//
//   Optional feature: define HAZARD_STATS_EN to build saturating stall and
//   forward counters. Without it, stall_cnt_o and fwd_cnt_o are tied to 0.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   hold_i         freeze all tracker state (no shift, no latch)
//   flush_i        kill the ID instruction so it never enters EX
//   id_valid_i     ID instruction valid
//   id_rd_i        ID destination register
//   id_regwrite_i  ID instruction writes the register file
//   id_is_load_i   ID instruction is a load
//   id_src_i       ID source addresses, operand i at [i*AW +: AW]
//   id_src_used_i  per-operand "source actually read" flag
//   stall_o        hold PC and IF/ID this cycle
//   fwd_sel_o      per-operand select for EX: 0 = regfile, k = stage k
//   stall_cnt_o    saturating stall-cycle count (HAZARD_STATS_EN)
//   fwd_cnt_o      saturating non-zero-forward count (HAZARD_STATS_EN)
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int AW         = 5,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hold_i,
  input  logic                 flush_i,
  input  logic                 id_valid_i,
  input  logic [AW-1:0]        id_rd_i,
  input  logic                 id_regwrite_i,
  input  logic                 id_is_load_i,
  input  logic [NSRC*AW-1:0]   id_src_i,
  input  logic [NSRC-1:0]      id_src_used_i,
  output logic                 stall_o,
  output logic [NSRC*SELW-1:0] fwd_sel_o,
  output logic [15:0]          stall_cnt_o,
  output logic [15:0]          fwd_cnt_o
);

  // Shadow pipeline, index 0 = instruction currently in EX.
  logic [DEPTH:0]               v_q, v_d;
  logic [DEPTH:0]               wr_q, wr_d;
  logic [DEPTH:0]               ld_q, ld_d;
  logic [DEPTH:0][AW-1:0]       rd_q, rd_d;
  logic [NSRC-1:0][AW-1:0]      ex_src_q, ex_src_d;
  logic [NSRC-1:0]              ex_used_q, ex_used_d;

  logic [DEPTH:0]               prod_s;
  logic [NSRC-1:0][SELW-1:0]    sel_s;
  logic                         hit_s;
  logic                         stall_s;
  logic                         take_s;

  // Producer qualifier: valid, writes, and not r0.
  always_comb begin
    for (int s = 0; s <= DEPTH; s++) begin
      prod_s[s] = v_q[s] & wr_q[s] & (rd_q[s] != {AW{1'b0}});
    end
  end

  // Forward select: scan oldest to youngest so the youngest match wins.
  // A load in a stage that does not yet carry load data never qualifies.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      sel_s[i] = {SELW{1'b0}};
      for (int k = DEPTH; k >= 1; k--) begin
        if (ex_used_q[i] && prod_s[k] && (rd_q[k] == ex_src_q[i]) &&
            !((k < LOAD_STAGE) && ld_q[k])) begin
          sel_s[i] = SELW'(k);
        end else begin
          sel_s[i] = sel_s[i];
        end
      end
    end
  end

  // Load-use detection against loads still short of their data stage.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int s = 0; s < LOAD_STAGE - 1; s++) begin
        if (id_src_used_i[i] && prod_s[s] && ld_q[s] &&
            (rd_q[s] == id_src_i[i*AW +: AW])) begin
          hit_s = 1'b1;
        end else begin
          hit_s = hit_s;
        end
      end
    end
  end

  // Flush overrides stall; the killed instruction becomes a bubble anyway.
  assign stall_s   = id_valid_i & ~flush_i & hit_s;
  assign take_s    = id_valid_i & ~stall_s & ~flush_i;
  assign stall_o   = stall_s;
  assign fwd_sel_o = sel_s;

  // Next state: shift the tag pipeline and latch ID or a bubble into EX.
  always_comb begin
    v_d       = v_q;
    wr_d      = wr_q;
    ld_d      = ld_q;
    rd_d      = rd_q;
    ex_src_d  = ex_src_q;
    ex_used_d = ex_used_q;
    if (!hold_i) begin
      v_d[DEPTH:1]  = v_q[DEPTH-1:0];
      wr_d[DEPTH:1] = wr_q[DEPTH-1:0];
      ld_d[DEPTH:1] = ld_q[DEPTH-1:0];
      rd_d[DEPTH:1] = rd_q[DEPTH-1:0];
      if (take_s) begin
        v_d[0]    = 1'b1;
        wr_d[0]   = id_regwrite_i;
        ld_d[0]   = id_is_load_i;
        rd_d[0]   = id_rd_i;
        ex_src_d  = id_src_i;
        ex_used_d = id_src_used_i;
      end else begin
        v_d[0]    = 1'b0;
        ex_used_d = {NSRC{1'b0}};
      end
    end else begin
      v_d = v_q;
    end
  end

  // Tag pipeline state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q       <= '0;
      wr_q      <= '0;
      ld_q      <= '0;
      rd_q      <= '0;
      ex_src_q  <= '0;
      ex_used_q <= '0;
    end else begin
      v_q       <= v_d;
      wr_q      <= wr_d;
      ld_q      <= ld_d;
      rd_q      <= rd_d;
      ex_src_q  <= ex_src_d;
      ex_used_q <= ex_used_d;
    end
  end

  // Load flags of stages at or past LOAD_STAGE are carried but never read.
  logic unused_ld_s;
  assign unused_ld_s = ^ld_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters, frozen while hold is high.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!hold_i && stall_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (!hold_i && (|sel_s) && (fwd_cnt_q != 16'hFFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 16'h0001;
    end else begin
      fwd_cnt_d = fwd_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 16'h0000;
      fwd_cnt_q   <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
  assign fwd_cnt_o   = 16'h0000;
`endif

endmodule
